// File: rtl/fpu_fmul_sched.sv
// fpu_fmul_sched: shares one FMUL datapath between scalar FPU issue (port 0)
// and the FIPR/FTRV vector sequencer (port 1). Round-robin arbitration with an
// atomic burst mode for port 1, per-port credit limit, tagged result routing
// and a sticky in-order return check.
module fpu_fmul_sched #(
  parameter int unsigned MAX_OUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [35:0] req0_a,
  input  logic [35:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [35:0] req1_a,
  input  logic [35:0] req1_b,
  input  logic [2:0]  req1_burst,
  output logic        m_valid,
  output logic [4:0]  m_tag,
  output logic [35:0] m_a,
  output logic [35:0] m_b,
  input  logic        m_r_valid,
  input  logic [4:0]  m_r_tag,
  input  logic [61:0] m_r_data,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [3:0]  rsp_tag,
  output logic [61:0] rsp_data,
  output logic        seq_err
);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e      state_q, state_d;
  logic [2:0]  beats_q, beats_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  seq_q [2];
  logic [3:0]  seq_d [2];
  logic [3:0]  out_q [2];
  logic [3:0]  out_d [2];
  logic [3:0]  exp_q [2];
  logic [3:0]  exp_d [2];
  logic        seq_err_q, seq_err_d;

  logic        m_valid_q, m_valid_d;
  logic [4:0]  m_tag_q, m_tag_d;
  logic [35:0] m_a_q, m_a_d, m_b_q, m_b_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [3:0]  rsp_tag_q, rsp_tag_d;
  logic [61:0] rsp_data_q, rsp_data_d;

  logic [1:0]  credit;
  logic [1:0]  grant;
  logic [1:0]  acc;

  // Grant selection: burst locks out port 0, otherwise round-robin among
  // requesters that still have credit; flush withholds all grants.
  always_comb begin
    credit[0] = (out_q[0] < 4'(MAX_OUT));
    credit[1] = (out_q[1] < 4'(MAX_OUT));
    grant     = '0;
    if (!flush) begin
      if (state_q == S_BURST) begin
        grant[1] = req1_valid & credit[1];
      end else if (req0_valid & credit[0] & req1_valid & credit[1]) begin
        grant[0] = last_grant_q;
        grant[1] = ~last_grant_q;
      end else begin
        grant[0] = req0_valid & credit[0];
        grant[1] = req1_valid & credit[1];
      end
    end
    req0_ready = grant[0];
    req1_ready = grant[1];
    acc        = {req1_valid & req1_ready, req0_valid & req0_ready};
  end

  // Burst FSM and round-robin pointer.
  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    last_grant_d = last_grant_q;
    if (acc[0]) last_grant_d = 1'b0;
    else if (acc[1]) last_grant_d = 1'b1;
    if (flush) begin
      state_d = S_IDLE;
      beats_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acc[1] && (req1_burst >= 3'd2)) begin
            state_d = S_BURST;
            beats_d = req1_burst - 3'd1;
          end
        end
        S_BURST: begin
          if (acc[1]) begin
            beats_d = beats_q - 3'd1;
            if (beats_q == 3'd1) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Issue register, per-port sequence/credit/order tracking, response register.
  always_comb begin
    m_valid_d   = |acc;
    m_tag_d     = m_tag_q;
    m_a_d       = m_a_q;
    m_b_d       = m_b_q;
    seq_err_d   = seq_err_q;
    rsp_valid_d = {m_r_valid & m_r_tag[4], m_r_valid & ~m_r_tag[4]};
    rsp_tag_d   = rsp_tag_q;
    rsp_data_d  = rsp_data_q;
    if (acc[0]) begin
      m_tag_d = {1'b0, seq_q[0]};
      m_a_d   = req0_a;
      m_b_d   = req0_b;
    end else if (acc[1]) begin
      m_tag_d = {1'b1, seq_q[1]};
      m_a_d   = req1_a;
      m_b_d   = req1_b;
    end
    if (m_r_valid) begin
      rsp_tag_d  = m_r_tag[3:0];
      rsp_data_d = m_r_data;
    end
    for (int unsigned k = 0; k < 2; k++) begin
      logic dec;
      dec      = m_r_valid & (m_r_tag[4] == 1'(k));
      seq_d[k] = seq_q[k] + {3'd0, acc[k]};
      exp_d[k] = exp_q[k] + {3'd0, dec};
      out_d[k] = out_q[k];
      // A simultaneous accept and result cancel; a stray result cannot
      // drive the count below zero.
      if (acc[k] && !dec) out_d[k] = out_q[k] + 4'd1;
      else if (dec && !acc[k] && (out_q[k] != '0)) out_d[k] = out_q[k] - 4'd1;
      if (dec && ((out_q[k] == '0) || (m_r_tag[3:0] != exp_q[k]))) seq_err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beats_q      <= '0;
      last_grant_q <= 1'b1;
      seq_err_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_tag_q      <= '0;
      m_a_q        <= '0;
      m_b_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_tag_q    <= '0;
      rsp_data_q   <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        seq_q[k] <= '0;
        out_q[k] <= '0;
        exp_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      last_grant_q <= last_grant_d;
      seq_err_q    <= seq_err_d;
      m_valid_q    <= m_valid_d;
      m_tag_q      <= m_tag_d;
      m_a_q        <= m_a_d;
      m_b_q        <= m_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_data_q   <= rsp_data_d;
      for (int unsigned k = 0; k < 2; k++) begin
        seq_q[k] <= seq_d[k];
        out_q[k] <= out_d[k];
        exp_q[k] <= exp_d[k];
      end
    end
  end

  assign m_valid    = m_valid_q;
  assign m_tag      = m_tag_q;
  assign m_a        = m_a_q;
  assign m_b        = m_b_q;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp_tag    = rsp_tag_q;
  assign rsp_data   = rsp_data_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_fpu_fmul_sched.sv
// Bench for fpu_fmul_sched: expected grants are scripted per scenario,
// expected issues and responses go through scoreboard queues.
module tb_fpu_fmul_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [35:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req1_burst = '0;
  logic        m_valid;
  logic [4:0]  m_tag;
  logic [35:0] m_a, m_b;
  logic        m_r_valid = 1'b0;
  logic [4:0]  m_r_tag = '0;
  logic [61:0] m_r_data = '0;
  logic        rsp0_valid, rsp1_valid;
  logic [3:0]  rsp_tag;
  logic [61:0] rsp_data;
  logic        seq_err;

  typedef struct {logic [4:0] tag; logic [35:0] a; logic [35:0] b;} iss_t;
  typedef struct {bit port; logic [3:0] tag; logic [61:0] data;} rsp_t;

  iss_t       iq[$];
  rsp_t       rq[$];
  logic [3:0] sq[2];
  int         total = 0;
  int         bad = 0;

  fpu_fmul_sched #(.MAX_OUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_burst(req1_burst),
    .m_valid(m_valid), .m_tag(m_tag), .m_a(m_a), .m_b(m_b),
    .m_r_valid(m_r_valid), .m_r_tag(m_r_tag), .m_r_data(m_r_data),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_tag(rsp_tag),
    .rsp_data(rsp_data), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs, check acceptance before the edge,
  // then check issue/response outputs just after it. eg: -1 none, 0/1 port.
  task automatic drive(input bit v0, input bit v1, input logic [2:0] burst, input bit fl,
                       input bit rv, input logic [4:0] rtag, input int eg, input string nm);
    iss_t is;
    rsp_t rs;
    bit   a0, a1;
    req0_valid = v0;
    req1_valid = v1;
    req1_burst = burst;
    flush      = fl;
    req0_a     = {4'($urandom), $urandom()};
    req0_b     = {4'($urandom), $urandom()};
    req1_a     = {4'($urandom), $urandom()};
    req1_b     = {4'($urandom), $urandom()};
    m_r_valid  = rv;
    m_r_tag    = rtag;
    m_r_data   = {30'($urandom), $urandom()};
    #1;
    a0 = req0_valid & req0_ready;
    a1 = req1_valid & req1_ready;
    total++;
    if (a0 !== (eg == 0) || a1 !== (eg == 1)) begin
      bad++;
      $display("FAIL %s accept got0=%0b got1=%0b exp_port=%0d", nm, a0, a1, eg);
    end
    if (eg == 0) begin
      is = '{tag: {1'b0, sq[0]}, a: req0_a, b: req0_b};
      iq.push_back(is);
      sq[0] = sq[0] + 4'd1;
    end else if (eg == 1) begin
      is = '{tag: {1'b1, sq[1]}, a: req1_a, b: req1_b};
      iq.push_back(is);
      sq[1] = sq[1] + 4'd1;
    end
    if (rv) begin
      rs = '{port: rtag[4], tag: rtag[3:0], data: m_r_data};
      rq.push_back(rs);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    flush      = 1'b0;
    m_r_valid  = 1'b0;
    total++;
    if (iq.size() > 0) begin
      is = iq.pop_front();
      if (m_valid !== 1'b1 || m_tag !== is.tag || m_a !== is.a || m_b !== is.b) begin
        bad++;
        $display("FAIL %s issue got v=%0b tag=%h a=%h b=%h exp v=1 tag=%h a=%h b=%h",
                 nm, m_valid, m_tag, m_a, m_b, is.tag, is.a, is.b);
      end
    end else if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s issue got m_valid=%0b exp 0", nm, m_valid);
    end
    total++;
    if (rq.size() > 0) begin
      rs = rq.pop_front();
      if (rsp0_valid !== !rs.port || rsp1_valid !== rs.port || rsp_tag !== rs.tag ||
          rsp_data !== rs.data) begin
        bad++;
        $display("FAIL %s rsp got v0=%0b v1=%0b tag=%h data=%h exp port=%0d tag=%h data=%h",
                 nm, rsp0_valid, rsp1_valid, rsp_tag, rsp_data, rs.port, rs.tag, rs.data);
      end
    end else if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s rsp got v0=%0b v1=%0b exp none", nm, rsp0_valid, rsp1_valid);
    end
  endtask

  task automatic check_err(input logic exp, input string nm);
    total++;
    if (seq_err !== exp) begin
      bad++;
      $display("FAIL %s seq_err got=%0b exp=%0b", nm, seq_err, exp);
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset(input string nm);
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    flush      = 1'b0;
    m_r_valid  = 1'b0;
    req1_burst = '0;
    #1;
    total++;
    if ({m_valid, m_tag, m_a, m_b, rsp0_valid, rsp1_valid, rsp_tag, rsp_data, seq_err,
         req0_ready, req1_ready} !== '0) begin
      bad++;
      $display("FAIL %s reset outputs m_valid=%0b m_tag=%h rsp0=%0b rsp1=%0b rsp_tag=%h seq_err=%0b",
               nm, m_valid, m_tag, rsp0_valid, rsp1_valid, rsp_tag, seq_err);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    iq.delete();
    rq.delete();
    sq[0] = '0;
    sq[1] = '0;
  endtask

  task automatic test_reset();
    apply_reset("reset");
    drive(0, 0, 3'd0, 0, 0, 5'h00, -1, "reset_idle");
    check_err(1'b0, "reset_err");
  endtask

  task automatic test_single();
    apply_reset("single_rst");
    drive(1, 0, 3'd0, 0, 0, 5'h00, 0, "single_issue");
    drive(0, 0, 3'd0, 0, 1, 5'h00, -1, "single_rsp");
    check_err(1'b0, "single_err");
  endtask

  task automatic test_round_robin();
    apply_reset("rr_rst");
    for (int i = 0; i < 4; i++) drive(1, 1, 3'd0, 0, 0, 5'h00, i % 2, "rr_grant");
    drive(0, 0, 3'd0, 0, 1, 5'h10, -1, "rr_rsp1");
    drive(0, 0, 3'd0, 0, 1, 5'h00, -1, "rr_rsp0");
    check_err(1'b0, "rr_err");
  endtask

  task automatic test_burst();
    apply_reset("burst_rst");
    drive(1, 0, 3'd0, 0, 0, 5'h00, 0, "burst_pre");
    drive(1, 1, 3'd4, 0, 0, 5'h00, 1, "burst_b1");
    drive(1, 1, 3'd0, 0, 0, 5'h00, 1, "burst_b2");
    drive(1, 0, 3'd0, 0, 0, 5'h00, -1, "burst_bubble");
    drive(1, 1, 3'd0, 0, 0, 5'h00, 1, "burst_b3");
    drive(1, 1, 3'd0, 0, 0, 5'h00, 1, "burst_b4");
    drive(1, 1, 3'd0, 0, 0, 5'h00, 0, "burst_after");
  endtask

  task automatic test_credit();
    apply_reset("credit_rst");
    for (int i = 0; i < 8; i++) drive(1, 0, 3'd0, 0, 0, 5'h00, 0, "credit_fill");
    drive(1, 0, 3'd0, 0, 0, 5'h00, -1, "credit_full");
    drive(1, 0, 3'd0, 0, 1, 5'h00, -1, "credit_ret");
    drive(1, 0, 3'd0, 0, 0, 5'h00, 0, "credit_one_more");
    drive(1, 0, 3'd0, 0, 0, 5'h00, -1, "credit_full2");
    check_err(1'b0, "credit_err");
  endtask

  task automatic test_order();
    apply_reset("order_rst");
    drive(1, 0, 3'd0, 0, 0, 5'h00, 0, "order_iss0");
    drive(1, 0, 3'd0, 0, 0, 5'h00, 0, "order_iss1");
    check_err(1'b0, "order_clean");
    drive(0, 0, 3'd0, 0, 1, 5'h01, -1, "order_rsp1");
    check_err(1'b1, "order_set");
    drive(0, 0, 3'd0, 0, 1, 5'h00, -1, "order_rsp0");
    drive(0, 0, 3'd0, 0, 0, 5'h00, -1, "order_idle");
    check_err(1'b1, "order_sticky");
    apply_reset("order_clear");
    check_err(1'b0, "order_cleared");
  endtask

  task automatic test_underflow();
    apply_reset("uflow_rst");
    drive(0, 0, 3'd0, 0, 1, 5'h10, -1, "uflow_rsp");
    check_err(1'b1, "uflow_err");
    for (int i = 0; i < 8; i++) drive(0, 1, 3'd0, 0, 0, 5'h00, 1, "uflow_fill");
    drive(0, 1, 3'd0, 0, 0, 5'h00, -1, "uflow_full");
  endtask

  task automatic test_flush();
    apply_reset("flush_rst");
    drive(1, 0, 3'd0, 0, 0, 5'h00, 0, "flush_pre");
    drive(1, 1, 3'd4, 0, 0, 5'h00, 1, "flush_b1");
    drive(1, 1, 3'd0, 0, 0, 5'h00, 1, "flush_b2");
    drive(1, 1, 3'd0, 1, 0, 5'h00, -1, "flush_cycle");
    drive(1, 1, 3'd0, 0, 0, 5'h00, 0, "flush_idle");
    for (int i = 0; i < 5; i++) drive(1, 0, 3'd0, 0, 0, 5'h00, 0, "flush_fill");
    drive(1, 0, 3'd0, 0, 1, 5'h00, 0, "flush_acc_rsp");
    drive(1, 0, 3'd0, 0, 0, 5'h00, 0, "flush_last");
    drive(1, 0, 3'd0, 0, 0, 5'h00, -1, "flush_full");
    check_err(1'b0, "flush_err");
    drive(1, 1, 3'd3, 0, 0, 5'h00, 1, "flush_reburst");
    apply_reset("midburst_rst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_credit();
    test_order();
    test_underflow();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
